// File: rtl/ex_wb_arbiter_pkg.sv
// Shared types and constants for the execute-stage writeback arbiter.
// Entry layout mirrors what the scoreboard write ports expect.
package ex_wb_arbiter_pkg;

  localparam int unsigned XLEN          = 64;
  localparam int unsigned TRANS_ID_BITS = 3;
  localparam int unsigned NR_WB_CH      = 4;

  typedef logic [XLEN-1:0] xlen_t;

  typedef struct packed {
    xlen_t cause;
    xlen_t tval;
    logic  valid;
  } exception_t;

  typedef struct packed {
    xlen_t                    result;
    logic [TRANS_ID_BITS-1:0] trans_id;
    exception_t               ex;
  } wb_entry_t;

  // Index width that never collapses to zero bits for single-entry ranges.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ex_wb_arbiter_if.sv
// Producer-side result channels and scoreboard-side write ports of the arbiter.
// The arbiter uses the slave modport; whoever drives results uses master.
interface ex_wb_arbiter_if
  import ex_wb_arbiter_pkg::*;
#(
  parameter int unsigned NR_CH       = NR_WB_CH,
  parameter int unsigned NR_WB_PORTS = 2
);
  localparam int unsigned CH_W = idx_w(NR_CH);

  logic       [NR_CH-1:0]                    in_valid;
  logic       [NR_CH-1:0]                    in_ready;
  logic       [NR_CH-1:0][XLEN-1:0]          in_result;
  logic       [NR_CH-1:0][TRANS_ID_BITS-1:0] in_trans_id;
  exception_t [NR_CH-1:0]                    in_ex;

  logic       [NR_WB_PORTS-1:0]                    wb_valid;
  logic       [NR_WB_PORTS-1:0][XLEN-1:0]          wb_result;
  logic       [NR_WB_PORTS-1:0][TRANS_ID_BITS-1:0] wb_trans_id;
  exception_t [NR_WB_PORTS-1:0]                    wb_ex;
  logic       [NR_WB_PORTS-1:0][CH_W-1:0]          wb_ch;

  logic       [NR_CH-1:0]                    ch_pending;

  modport master (
    output in_valid, in_result, in_trans_id, in_ex,
    input  in_ready, wb_valid, wb_result, wb_trans_id, wb_ex, wb_ch, ch_pending
  );

  modport slave (
    input  in_valid, in_result, in_trans_id, in_ex,
    output in_ready, wb_valid, wb_result, wb_trans_id, wb_ex, wb_ch, ch_pending
  );

endinterface

// File: rtl/ex_wb_arbiter_wb_fifo.sv
// Per-channel result FIFO: register storage with explicit occupancy count.
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module wb_fifo
  import ex_wb_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      clear_i,
  input  logic      push_i,
  input  logic      pop_i,
  input  wb_entry_t data_i,
  output logic      full_o,
  output logic      empty_o,
  output wb_entry_t data_o
);

  localparam int unsigned PTR_W = idx_w(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  wb_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    cnt_d    = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Data array carries no reset; the head is only observed when non-empty.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/ex_wb_arbiter.sv
// Buffers results from NR_CH functional units and grants up to NR_WB_PORTS per
// cycle: fixed-priority channels first, then round-robin over the rest.
module ex_wb_arbiter
  import ex_wb_arbiter_pkg::*;
#(
  parameter int unsigned      NR_CH       = NR_WB_CH,
  parameter int unsigned      NR_WB_PORTS = 2,
  parameter int unsigned      FIFO_DEPTH  = 2,
  parameter logic [NR_CH-1:0] HIGH_PRIO   = NR_CH'(1)
) (
  input logic            clk_i,
  input logic            rst_i,
  input logic            flush_i,
  ex_wb_arbiter_if.slave wb_if
);

  localparam int unsigned CH_W   = idx_w(NR_CH);
  localparam int unsigned PORT_W = idx_w(NR_WB_PORTS);

  wb_entry_t [NR_CH-1:0]                 head;
  logic      [NR_CH-1:0]                 full, empty, push, pop, grant;
  logic      [NR_WB_PORTS-1:0]           port_vld;
  logic      [NR_WB_PORTS-1:0][CH_W-1:0] port_ch;
  logic      [CH_W-1:0]                  rr_ptr_q, rr_ptr_d;
  logic      [PORT_W:0]                  n_gnt;
  logic      [CH_W:0]                    rr_idx;
  logic      [CH_W-1:0]                  rr_ch;
  logic                                  kill;

  assign kill = rst_i | flush_i;

  for (genvar c = 0; c < NR_CH; c++) begin : g_fifo
    wb_entry_t in_entry;
    assign in_entry = '{result:   wb_if.in_result[c],
                        trans_id: wb_if.in_trans_id[c],
                        ex:       wb_if.in_ex[c]};
    wb_fifo #(.DEPTH(FIFO_DEPTH)) i_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clear_i (flush_i),
      .push_i  (push[c]),
      .pop_i   (pop[c]),
      .data_i  (in_entry),
      .full_o  (full[c]),
      .empty_o (empty[c]),
      .data_o  (head[c])
    );
  end

  assign wb_if.in_ready   = ~full & {NR_CH{~kill}};
  assign push             = wb_if.in_valid & wb_if.in_ready;
  assign pop              = grant & {NR_CH{~kill}};
  assign wb_if.ch_pending = ~empty & {NR_CH{~rst_i}};

  // Grants are filled in order; the running count n_gnt selects the port.
  always_comb begin
    grant    = '0;
    port_vld = '0;
    port_ch  = '0;
    rr_ptr_d = rr_ptr_q;
    n_gnt    = '0;
    rr_idx   = '0;
    rr_ch    = '0;
    for (int unsigned i = 0; i < NR_CH; i++) begin
      if (HIGH_PRIO[i] && !empty[i] && (n_gnt < (PORT_W+1)'(NR_WB_PORTS))) begin
        grant[i]                   = 1'b1;
        port_vld[n_gnt[PORT_W-1:0]] = 1'b1;
        port_ch[n_gnt[PORT_W-1:0]]  = CH_W'(i);
        n_gnt                       = n_gnt + (PORT_W+1)'(1);
      end
    end
    for (int unsigned i = 0; i < NR_CH; i++) begin
      rr_idx = {1'b0, rr_ptr_q} + (CH_W+1)'(i);
      if (rr_idx >= (CH_W+1)'(NR_CH)) rr_idx = rr_idx - (CH_W+1)'(NR_CH);
      rr_ch = rr_idx[CH_W-1:0];
      if (!HIGH_PRIO[rr_ch] && !empty[rr_ch] && (n_gnt < (PORT_W+1)'(NR_WB_PORTS))) begin
        grant[rr_ch]                = 1'b1;
        port_vld[n_gnt[PORT_W-1:0]] = 1'b1;
        port_ch[n_gnt[PORT_W-1:0]]  = rr_ch;
        n_gnt                       = n_gnt + (PORT_W+1)'(1);
        rr_ptr_d = (rr_ch == CH_W'(NR_CH - 1)) ? '0 : rr_ch + CH_W'(1);
      end
    end
    if (flush_i) rr_ptr_d = rr_ptr_q;
  end

  always_comb begin
    wb_if.wb_valid    = '0;
    wb_if.wb_result   = '0;
    wb_if.wb_trans_id = '0;
    wb_if.wb_ex       = '0;
    wb_if.wb_ch       = '0;
    for (int unsigned k = 0; k < NR_WB_PORTS; k++) begin
      if (port_vld[k] && !kill) begin
        wb_if.wb_valid[k]    = 1'b1;
        wb_if.wb_result[k]   = head[port_ch[k]].result;
        wb_if.wb_trans_id[k] = head[port_ch[k]].trans_id;
        wb_if.wb_ex[k]       = head[port_ch[k]].ex;
        wb_if.wb_ch[k]       = port_ch[k];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) rr_ptr_q <= '0;
    else       rr_ptr_q <= rr_ptr_d;
  end

endmodule

// File: tb/tb_ex_wb_arbiter.sv
// Directed bench: one round-robin-only arbiter and one with ch0 high priority,
// driven from shared stimulus; valid is held off while a channel is not ready.
module tb_ex_wb_arbiter;
  import ex_wb_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic [3:0] want = '0;
  logic [3:0][XLEN-1:0] res = '0;
  logic [3:0][TRANS_ID_BITS-1:0] tid = '0;
  exception_t [3:0] ex = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ex_wb_arbiter_if #(.NR_CH(4), .NR_WB_PORTS(2)) bus_rr ();
  ex_wb_arbiter_if #(.NR_CH(4), .NR_WB_PORTS(2)) bus_hp ();

  assign bus_rr.in_valid    = want & (bus_rr.in_ready | {4{rst | flush}});
  assign bus_rr.in_result   = res;
  assign bus_rr.in_trans_id = tid;
  assign bus_rr.in_ex       = ex;
  assign bus_hp.in_valid    = want & (bus_hp.in_ready | {4{rst | flush}});
  assign bus_hp.in_result   = res;
  assign bus_hp.in_trans_id = tid;
  assign bus_hp.in_ex       = ex;

  ex_wb_arbiter #(.NR_CH(4), .NR_WB_PORTS(2), .FIFO_DEPTH(2), .HIGH_PRIO(4'b0000)) dut_rr (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .wb_if(bus_rr));
  ex_wb_arbiter #(.NR_CH(4), .NR_WB_PORTS(2), .FIFO_DEPTH(2), .HIGH_PRIO(4'b0001)) dut_hp (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .wb_if(bus_hp));

  always @(posedge clk) begin
    if (!rst && !flush) begin
      assert ((bus_rr.in_valid & ~bus_rr.in_ready) == 4'b0) else $error("push while not ready (rr)");
      assert ((bus_hp.in_valid & ~bus_hp.in_ready) == 4'b0) else $error("push while not ready (hp)");
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    flush = 1'b0;
    want = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  typedef struct {
    logic [3:0] want;
    logic [1:0] vld;
    logic [1:0] rr_c0, rr_c1;
    logic [3:0] rr_rdy;
    logic [1:0] hp_c0, hp_c1;
    logic [3:0] hp_rdy;
  } vec_t;

  vec_t vecs [10];
  int   gcnt [4];

  initial begin
    vecs[0] = '{4'b1111, 2'b11, 2'd0, 2'd1, 4'b1111, 2'd0, 2'd1, 4'b1111};
    vecs[1] = '{4'b1111, 2'b11, 2'd2, 2'd3, 4'b0011, 2'd0, 2'd2, 4'b0011};
    vecs[2] = '{4'b1111, 2'b11, 2'd0, 2'd1, 4'b1100, 2'd0, 2'd3, 4'b0101};
    vecs[3] = '{4'b1111, 2'b11, 2'd2, 2'd3, 4'b0011, 2'd0, 2'd1, 4'b1001};
    vecs[4] = '{4'b1111, 2'b11, 2'd0, 2'd1, 4'b1100, 2'd0, 2'd2, 4'b0011};
    vecs[5] = '{4'b1111, 2'b11, 2'd2, 2'd3, 4'b0011, 2'd0, 2'd3, 4'b0101};
    vecs[6] = '{4'b1111, 2'b11, 2'd0, 2'd1, 4'b1100, 2'd0, 2'd1, 4'b1001};
    vecs[7] = '{4'b0000, 2'b11, 2'd2, 2'd3, 4'b1111, 2'd2, 2'd3, 4'b1011};
    vecs[8] = '{4'b0000, 2'b11, 2'd0, 2'd1, 4'b1111, 2'd1, 2'd2, 4'b1111};
    vecs[9] = '{4'b0000, 2'b00, 2'd0, 2'd0, 4'b1111, 2'd0, 2'd0, 4'b1111};
    for (int c = 0; c < 4; c++) begin
      res[c] = XLEN'(64'h100 + c);
      tid[c] = TRANS_ID_BITS'(c);
    end

    // Reset with all channels asserting valid.
    rst = 1'b1;
    want = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("rst%0d_rr_vld", i), 64'(bus_rr.wb_valid), 64'h0);
      check($sformatf("rst%0d_rr_rdy", i), 64'(bus_rr.in_ready), 64'h0);
      check($sformatf("rst%0d_hp_rdy", i), 64'(bus_hp.in_ready), 64'h0);
      check($sformatf("rst%0d_pend", i), 64'(bus_rr.ch_pending), 64'h0);
    end
    rst = 1'b0;
    want = '0;
    #1;
    check("rel_rr_rdy", 64'(bus_rr.in_ready), 64'hF);
    check("rel_hp_rdy", 64'(bus_hp.in_ready), 64'hF);
    check("rel_pend", 64'(bus_rr.ch_pending), 64'h0);

    // Single result on ch2.
    do_reset();
    res[2] = XLEN'(64'hDEAD);
    tid[2] = 3'd5;
    ex[2]  = '{cause: XLEN'(2), tval: '0, valid: 1'b1};
    want   = 4'b0100;
    #1;
    check("single_nocomb", 64'(bus_rr.wb_valid), 64'h0);
    @(posedge clk); #1;
    want = '0;
    check("single_rr_vld", 64'(bus_rr.wb_valid), 64'h1);
    check("single_rr_res", 64'(bus_rr.wb_result[0]), 64'hDEAD);
    check("single_rr_tid", 64'(bus_rr.wb_trans_id[0]), 64'h5);
    check("single_rr_ch", 64'(bus_rr.wb_ch[0]), 64'h2);
    check("single_rr_exv", 64'(bus_rr.wb_ex[0].valid), 64'h1);
    check("single_rr_exc", 64'(bus_rr.wb_ex[0].cause), 64'h2);
    check("single_rr_p1res", 64'(bus_rr.wb_result[1]), 64'h0);
    check("single_rr_p1tid", 64'(bus_rr.wb_trans_id[1]), 64'h0);
    check("single_hp_vld", 64'(bus_hp.wb_valid), 64'h1);
    check("single_hp_ch", 64'(bus_hp.wb_ch[0]), 64'h2);
    check("single_pend", 64'(bus_rr.ch_pending), 64'h4);
    @(posedge clk); #1;
    check("single_pend_fall", 64'(bus_rr.ch_pending), 64'h0);
    check("single_vld_fall", 64'(bus_rr.wb_valid), 64'h0);
    ex[2] = '0;

    // Table: all channels pushing continuously, then draining.
    do_reset();
    for (int c = 0; c < 4; c++) gcnt[c] = 0;
    for (int i = 0; i < 10; i++) begin
      want = vecs[i].want;
      @(posedge clk); #1;
      check($sformatf("tbl%0d_rr_vld", i), 64'(bus_rr.wb_valid), 64'(vecs[i].vld));
      check($sformatf("tbl%0d_rr_c0", i), 64'(bus_rr.wb_ch[0]), 64'(vecs[i].rr_c0));
      check($sformatf("tbl%0d_rr_c1", i), 64'(bus_rr.wb_ch[1]), 64'(vecs[i].rr_c1));
      check($sformatf("tbl%0d_rr_rdy", i), 64'(bus_rr.in_ready), 64'(vecs[i].rr_rdy));
      check($sformatf("tbl%0d_hp_vld", i), 64'(bus_hp.wb_valid), 64'(vecs[i].vld));
      check($sformatf("tbl%0d_hp_c0", i), 64'(bus_hp.wb_ch[0]), 64'(vecs[i].hp_c0));
      check($sformatf("tbl%0d_hp_c1", i), 64'(bus_hp.wb_ch[1]), 64'(vecs[i].hp_c1));
      check($sformatf("tbl%0d_hp_rdy", i), 64'(bus_hp.in_ready), 64'(vecs[i].hp_rdy));
      if (i < 6) begin
        for (int k = 0; k < 2; k++)
          if (bus_rr.wb_valid[k]) gcnt[bus_rr.wb_ch[k]]++;
      end
    end
    for (int c = 0; c < 4; c++)
      check($sformatf("fair_ch%0d", c), 64'(gcnt[c]), 64'd3);

    // Full FIFO on ch3 of the priority arbiter.
    do_reset();
    res[3] = XLEN'(64'hA);
    want = 4'b1111;
    @(posedge clk); #1;
    check("full_c1_rdy3", 64'(bus_hp.in_ready[3]), 64'h1);
    check("full_c1_ch1", 64'(bus_hp.wb_ch[1]), 64'h1);
    res[3] = XLEN'(64'hB);
    want = 4'b1001;
    @(posedge clk); #1;
    check("full_c2_rdy3", 64'(bus_hp.in_ready[3]), 64'h0);
    check("full_c2_ch1", 64'(bus_hp.wb_ch[1]), 64'h2);
    res[3] = XLEN'(64'hC);
    want = 4'b1000;
    @(posedge clk); #1;
    check("full_c3_vld", 64'(bus_hp.wb_valid), 64'h1);
    check("full_c3_ch", 64'(bus_hp.wb_ch[0]), 64'h3);
    check("full_c3_res", 64'(bus_hp.wb_result[0]), 64'hA);
    check("full_c3_rdy3", 64'(bus_hp.in_ready[3]), 64'h0);
    @(posedge clk); #1;
    check("full_c4_res", 64'(bus_hp.wb_result[0]), 64'hB);
    check("full_c4_rdy3", 64'(bus_hp.in_ready[3]), 64'h1);
    @(posedge clk); #1;
    want = '0;
    check("full_c5_res", 64'(bus_hp.wb_result[0]), 64'hC);
    check("full_c5_vld", 64'(bus_hp.wb_valid), 64'h1);
    @(posedge clk); #1;
    check("full_c6_pend", 64'(bus_hp.ch_pending), 64'h0);

    // Flush mid-stream with a simultaneous push on ch1.
    do_reset();
    want = 4'b1111;
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush = 1'b1;
    want = 4'b0010;
    #1;
    check("flush_rr_vld", 64'(bus_rr.wb_valid), 64'h0);
    check("flush_hp_vld", 64'(bus_hp.wb_valid), 64'h0);
    check("flush_rr_rdy", 64'(bus_rr.in_ready), 64'h0);
    check("flush_rr_pend_pre", 64'(bus_rr.ch_pending), 64'hF);
    @(posedge clk); #1;
    flush = 1'b0;
    want = '0;
    check("flush_rr_pend", 64'(bus_rr.ch_pending), 64'h0);
    check("flush_hp_pend", 64'(bus_hp.ch_pending), 64'h0);
    check("flush_rr_vld2", 64'(bus_rr.wb_valid), 64'h0);
    @(posedge clk); #1;
    check("flush_no_ch1", 64'(bus_rr.ch_pending), 64'h0);
    want = 4'b1111;
    @(posedge clk); #1;
    want = '0;
    check("flush_rrhold_rr_c0", 64'(bus_rr.wb_ch[0]), 64'h2);
    check("flush_rrhold_rr_c1", 64'(bus_rr.wb_ch[1]), 64'h3);
    check("flush_rrhold_hp_c0", 64'(bus_hp.wb_ch[0]), 64'h0);
    check("flush_rrhold_hp_c1", 64'(bus_hp.wb_ch[1]), 64'h2);

    repeat (4) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_wb_arbiter.md
# ex_wb_arbiter

Parametrised writeback arbiter for the execute stage. It collects results from NR_CH functional-unit channels (ALU/branch, CSR, multiplier, PUF, FPU, CV-X-IF, …) into per-channel FIFOs. Each cycle it grants up to NR_WB_PORTS of them onto the scoreboard write ports. This replaces hard-wired result muxing with buffered, fair arbitration, so variable-latency units no longer need issue-side collision avoidance.

## Interface
- NR_CH, 4: number of producer channels, 1..8
- NR_WB_PORTS, 2: scoreboard write ports, 1..NR_CH
- FIFO_DEPTH, 2: entries per channel FIFO, power of two, ≥2
- HIGH_PRIO, 'b0001: NR_CH-bit mask; set channels are granted before round-robin channels
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- flush_i  in  1  synchronous flush of all buffered results
- in_valid_i  in  NR_CH  per-channel result valid
- in_ready_o  out  NR_CH  per-channel FIFO can accept
- in_result_i  in  NR_CH×XLEN  per-channel result data
- in_trans_id_i  in  NR_CH×TRANS_ID_BITS  per-channel scoreboard ID
- in_ex_i  in  NR_CH×exception_t  per-channel exception
- wb_valid_o  out  NR_WB_PORTS  write port k carries a result
- wb_result_o  out  NR_WB_PORTS×XLEN  result
- wb_trans_id_o  out  NR_WB_PORTS×TRANS_ID_BITS  scoreboard ID
- wb_ex_o  out  NR_WB_PORTS×exception_t  exception
- wb_ch_o  out  NR_WB_PORTS×clog2(NR_CH)  source channel, debug/RVFI only
- ch_pending_o  out  NR_CH  channel FIFO non-empty

## Operation
- Push: a channel FIFO accepts an entry when in_valid_i[c] & in_ready_o[c]. in_ready_o[c] = !full[c] & !flush_i & !rst_i. Pushing while ready is low is a protocol violation; the entry is dropped and the bench asserts on it.
- Arbitration each cycle, using the set R of non-empty channels:
  - Pass 1: HIGH_PRIO channels in R, ascending index.
  - Pass 2: remaining channels in R, ascending from rr_ptr with wrap.
  - The first NR_WB_PORTS channels selected are granted. The k-th grant drives port k. Ungranted ports have valid = 0 and all payload = 0.
- Pop: every granted FIFO pops its head at the clock edge. The scoreboard has no backpressure.
- rr_ptr updates only when at least one pass-2 channel is granted: it becomes (last pass-2 granted index + 1) mod NR_CH. Otherwise it holds.
- Starvation bound: a non-priority channel waits at most ceil((NR_CH−1)/NR_WB_PORTS) cycles, provided the HIGH_PRIO channels leave a port free.
- Flush: flush_i empties all FIFOs and forces wb_valid_o = 0 that cycle. Same-cycle pushes are ignored. rr_ptr holds.
- Reset: the same as flush, and rr_ptr = 0.
- Per-FIFO boundaries:
  - Push and pop on a non-full FIFO in the same cycle: count unchanged, order preserved.
  - Pop of the last entry: ch_pending_o falls next cycle.
  - Pointers wrap modulo FIFO_DEPTH.

## Timing
- Outputs are combinational from FIFO heads and rr_ptr only; there is no combinational path from in_* to wb_*.
- Minimum latency: push at edge t, earliest writeback in cycle t+1 (1 cycle).
- in_ready_o depends only on registered counts plus flush_i/rst_i.
- Output values during and after reset: wb_valid_o = 0, wb_* payload = 0, ch_pending_o = 0, in_ready_o = 0 while rst_i = 1 and all-ones in the first cycle after.
- Throughput: NR_WB_PORTS results per cycle. Each channel sustains 1 result per cycle when granted every cycle.

## Structure
- ariane_pkg gains:
  - typedef wb_entry_t {riscv::xlen_t result; logic [TRANS_ID_BITS-1:0] trans_id; exception_t ex;}
  - constant NR_WB_CH for the top-level channel count.
- Sub-module wb_fifo holds one channel's FIFO, instantiated NR_CH times.
  - Parameter: DEPTH.
  - Ports: push, pop, full, empty, head data.
  - Storage: registers with explicit count, synchronous clear.
- The arbiter is a single always_comb loop over channels plus an rr_ptr register in ex_wb_arbiter.

## Test plan
- Reset behaviour: assert rst_i for 3 cycles with in_valid_i = 'b1111 → wb_valid_o = 0, in_ready_o = 0 during reset. Cycle after release: in_ready_o = 'b1111, ch_pending_o = 0.
- Single result: push ch2 {result 0xDEAD, tid 5} at t → at t+1 port 0 shows valid = 1, 0xDEAD, tid 5, wb_ch 2; port 1 valid = 0. ch_pending_o = 0 at t+2.
- Round-robin fairness:
  - Setup: HIGH_PRIO = 0, all 4 channels continuously pushing, 2 ports.
  - Expected grants {0,1}, {2,3}, {0,1}, …; each channel gets 50% of cycles.
- Priority plus starvation bound:
  - Setup: HIGH_PRIO = 'b0001, all channels pushing.
  - Expected: ch0 holds port 0 every cycle; ch1..3 rotate on port 1; no channel waits more than 3 cycles.
- Full FIFO: FIFO_DEPTH = 2, ch3 pushes 3 times while losing arbitration → in_ready_o[3] = 0 after 2 entries. Entries then drain in FIFO order; ready returns the cycle after the first pop.
- Flush mid-stream: 2 entries in each of 4 FIFOs; assert flush_i with a simultaneous push on ch1 → that cycle wb_valid_o = 0. Next cycle all FIFOs are empty, ch_pending_o = 0, and the ch1 push is not present.
